// File: rtl/ctrl_encode_def.sv
// ---------------------------------------------------------------------------
// ctrl_encode_def
//   Shared encodings for the CPU control path: next-PC op codes, the fetch
//   FSM state encoding, and default reset / trap PC values used as parameter
//   defaults by the fetch controller.
//   No ports (package).
// ---------------------------------------------------------------------------
package ctrl_encode_def;

    // Next-PC selection op codes driven by decode into the next-PC logic
    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JALR   = 2'd3;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0100;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_REQ   = 2'd1,
        FS_WAIT  = 2'd2,
        FS_VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_target_sel.sv
// ---------------------------------------------------------------------------
// pc_target_sel
//   Combinational selection of the next PC to load: redirect target has
//   priority over npc. With PC_FETCH_ALIGN_CHK_EN defined, a target whose
//   low two bits are nonzero is replaced by TRAP_PC and flagged.
//   Ports:
//     redirect_i     select redirect_pc_i over npc_i
//     redirect_pc_i  redirect target
//     npc_i          sequential / branch next PC
//     target_o       PC value to load
//     misalign_o     selected target was misaligned (always 0 without macro)
//   Macro: PC_FETCH_ALIGN_CHK_EN enables the alignment check.
// ---------------------------------------------------------------------------
module pc_target_sel
    import ctrl_encode_def::*;
#(
    parameter logic [31:0] TRAP_PC = DEF_TRAP_PC
) (
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] npc_i,
    output logic [31:0] target_o,
    output logic        misalign_o
);

`ifdef PC_FETCH_ALIGN_CHK_EN
    localparam logic ALIGN_CHK = 1'b1;
`else
    localparam logic ALIGN_CHK = 1'b0;
`endif

    logic [31:0] raw_target;

    always_comb begin
        raw_target = redirect_i ? redirect_pc_i : npc_i;
        misalign_o = ALIGN_CHK & (|raw_target[1:0]);
        target_o   = misalign_o ? TRAP_PC : raw_target;
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//   Owns the architectural PC and fetches one instruction at a time over a
//   req/gnt/rvalid handshake, presenting it with its PC to decode. Handles
//   stall, and redirect at any point of a fetch (including while a request
//   is in flight, via a single kill bit that drops the stale response).
//   Ports:
//     clk, rstn                 clock, async active-low reset
//     npc_i                     next PC, sampled on advance
//     stall_i                   decode not ready, hold instruction
//     redirect_i/redirect_pc_i  flush and restart at redirect target
//     imem_req_o/imem_addr_o    fetch request / address (== pc_o)
//     imem_gnt_i, imem_rvalid_i, imem_rdata_i   memory handshake
//     inst_valid_o, inst_o, pc_o                 instruction to decode
//     misalign_o                pulse when a misaligned target is replaced
//   Macro: PC_FETCH_ALIGN_CHK_EN enables the misaligned-target trap.
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
    import ctrl_encode_def::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_PC  = DEF_TRAP_PC
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] npc_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        misalign_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic         kill_q, kill_d;
    logic         load_pc;
    logic [31:0]  target;
    logic         target_misalign;

    pc_target_sel #(
        .TRAP_PC (TRAP_PC)
    ) u_target_sel (
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .npc_i         (npc_i),
        .target_o      (target),
        .misalign_o    (target_misalign)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        kill_d       = kill_q;
        load_pc      = 1'b0;
        imem_req_o   = 1'b0;
        inst_valid_o = 1'b0;
        case (state_q)
            FS_IDLE: begin
                state_d = FS_REQ;
                load_pc = redirect_i;
            end
            FS_REQ: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    load_pc = 1'b1;
                    // granted at the old address: its response must be dropped
                    if (imem_gnt_i) begin
                        kill_d  = 1'b1;
                        state_d = FS_WAIT;
                    end
                end else if (imem_gnt_i) begin
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (redirect_i) begin
                    load_pc = 1'b1;
                    if (imem_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    kill_d = 1'b0;
                    if (kill_q) begin
                        state_d = FS_REQ;
                    end else begin
                        inst_d  = imem_rdata_i;
                        state_d = FS_VALID;
                    end
                end
            end
            FS_VALID: begin
                inst_valid_o = 1'b1;
                if (redirect_i || !stall_i) begin
                    load_pc = 1'b1;
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_IDLE;
        endcase
        if (load_pc) begin
            pc_d = target;
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;
    assign misalign_o  = load_pc & target_misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] npc_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        misalign_o;

`ifdef PC_FETCH_ALIGN_CHK_EN
    localparam logic [31:0] EXP_MIS_ADDR = 32'h0000_0100;
    localparam logic        EXP_MIS      = 1'b1;
`else
    localparam logic [31:0] EXP_MIS_ADDR = 32'h0000_0006;
    localparam logic        EXP_MIS      = 1'b0;
`endif

    pc_fetch_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .npc_i         (npc_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .misalign_o    (misalign_o)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb_q[$];

    task automatic expect_fetch(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.inst = mem_word(a);
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Memory model: grants after gnt_delay REQ cycles, returns data
    // rvalid_delay cycles after the grant cycle + 1. A pending response
    // survives DUT reset so a late rvalid can be delivered.
    int          gnt_delay = 0;
    int          rvalid_delay = 0;
    int          gnt_cnt = 0;
    int          rv_cnt = 0;
    bit          pend = 1'b0;
    bit          stale = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    initial begin
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
            if (pend) begin
                if (rv_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = stale ? 32'hDEAD_BEEF : mem_word(pend_addr);
                    stale         = 1'b0;
                    pend          = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (imem_req_o) begin
                if (gnt_cnt >= gnt_delay) begin
                    imem_gnt_i = 1'b1;
                    pend       = 1'b1;
                    pend_addr  = imem_addr_o;
                    rv_cnt     = rvalid_delay;
                    gnt_cnt    = 0;
                end else begin
                    gnt_cnt++;
                end
            end
        end
    end

    // Scoreboard consumer: each new presentation to decode pops one expectation
    initial begin
        bit   prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_v = 1'b0;
            end else begin
                if (inst_valid_o && !prev_v) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_valid", {31'h0, inst_valid_o}, 32'h0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_pc", pc_o, e.pc);
                        chk("sb_inst", inst_o, e.inst);
                    end
                end
                prev_v = inst_valid_o;
            end
        end
    end

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!inst_valid_o && n < 20) begin
            tick();
            n++;
        end
        if (!inst_valid_o) chk({tag, "_timeout"}, {31'h0, inst_valid_o}, 32'h1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, {31'h0, imem_req_o}, 32'h0);
        chk({tag, "_valid"}, {31'h0, inst_valid_o}, 32'h0);
        chk({tag, "_inst"}, inst_o, 32'h0);
        chk({tag, "_pc"}, pc_o, 32'h0);
        chk({tag, "_mis"}, {31'h0, misalign_o}, 32'h0);
    endtask

    initial begin
        repeat (3) tick();
        chk_all_zero("reset");

        // first fetch with zero-wait memory
        expect_fetch(32'h0);
        npc_i = 32'h4;
        rstn  = 1'b1;
        tick();
        chk("first_req", {31'h0, imem_req_o}, 32'h1);
        chk("first_addr", imem_addr_o, 32'h0);
        tick();
        chk("wait_no_req", {31'h0, imem_req_o}, 32'h0);
        tick();
        chk("valid_3rd_cycle", {31'h0, inst_valid_o}, 32'h1);
        expect_fetch(32'h4);
        tick();
        chk("adv_req", {31'h0, imem_req_o}, 32'h1);
        chk("adv_addr", imem_addr_o, 32'h4);

        // stall held 5 cycles in VALID
        wait_valid("stall");
        stall_i = 1'b1;
        npc_i   = 32'h8;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'h0, inst_valid_o}, 32'h1);
            chk("stall_no_req", {31'h0, imem_req_o}, 32'h0);
            chk("stall_pc", pc_o, 32'h4);
            chk("stall_inst", inst_o, mem_word(32'h4));
        end
        stall_i   = 1'b0;
        gnt_delay = 3;
        tick();
        chk("release_req", {31'h0, imem_req_o}, 32'h1);
        chk("release_addr", imem_addr_o, 32'h8);

        // redirect while waiting for a delayed grant
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        expect_fetch(32'h40);
        npc_i = 32'h44;
        tick();
        redirect_i = 1'b0;
        chk("redir_req_held", {31'h0, imem_req_o}, 32'h1);
        chk("redir_req_addr", imem_addr_o, 32'h40);
        wait_valid("gnt_delay");

        // redirect in WAIT, stale data returned afterwards
        gnt_delay    = 0;
        rvalid_delay = 2;
        tick();
        chk("req_44", imem_addr_o, 32'h44);
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h80;
        expect_fetch(32'h80);
        tick();
        redirect_i   = 1'b0;
        stale        = 1'b1;
        rvalid_delay = 0;
        stall_i      = 1'b1;
        chk("kill_no_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("kill_no_req", {31'h0, imem_req_o}, 32'h0);
        tick();
        chk("stale_no_valid", {31'h0, inst_valid_o}, 32'h0);
        tick();
        chk("refetch_req", {31'h0, imem_req_o}, 32'h1);
        chk("refetch_addr", imem_addr_o, 32'h80);
        chk("refetch_no_valid", {31'h0, inst_valid_o}, 32'h0);

        // redirect from VALID overrides stall; target at top of address space
        wait_valid("valid_redir");
        tick();
        chk("stalled_valid", {31'h0, inst_valid_o}, 32'h1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        expect_fetch(32'hFFFF_FFFC);
        tick();
        redirect_i = 1'b0;
        chk("vredir_drop", {31'h0, inst_valid_o}, 32'h0);
        chk("vredir_addr", imem_addr_o, 32'hFFFF_FFFC);
        stall_i = 1'b0;
        npc_i   = 32'h0;
        wait_valid("wrap");
        tick();
        chk("wrap_addr", imem_addr_o, 32'h0);
        chk("wrap_req", {31'h0, imem_req_o}, 32'h1);

        // redirect in the same cycle as the grant
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        expect_fetch(32'h200);
        tick();
        redirect_i = 1'b0;
        tick();
        chk("gnt_redir_req", {31'h0, imem_req_o}, 32'h1);
        chk("gnt_redir_addr", imem_addr_o, 32'h200);
        chk("gnt_redir_no_valid", {31'h0, inst_valid_o}, 32'h0);
        npc_i        = 32'h300;
        rvalid_delay = 3;
        wait_valid("pre_reset");

        // reset asserted mid-WAIT, late rvalid afterwards
        tick();
        tick();
        rstn = 1'b0;
        #1;
        chk_all_zero("midreset");
        expect_fetch(32'h0);
        rvalid_delay = 0;
        tick();
        rstn = 1'b1;
        tick();
        tick();
        tick();
        chk("late_rv_inst", inst_o, 32'h0);
        chk("late_rv_no_valid", {31'h0, inst_valid_o}, 32'h0);
        npc_i = 32'h6;
        wait_valid("post_reset");

        // misaligned advance target
        chk("mis_pulse", {31'h0, misalign_o}, {31'h0, EXP_MIS});
        expect_fetch(EXP_MIS_ADDR);
        tick();
        chk("mis_single", {31'h0, misalign_o}, 32'h0);
        chk("mis_addr", imem_addr_o, EXP_MIS_ADDR);
        stall_i = 1'b1;
        wait_valid("mis_fetch");
        tick();
        chk("sb_empty", sb_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the architectural PC register and sequences instruction fetch from instruction memory over a req/gnt/rvalid handshake.
- Presents one instruction at a time, with its PC, to decode. On consumer advance it loads the next PC produced by the combinational next-PC logic. It also handles pipeline stall and redirect/flush, including a redirect that arrives while a fetch is in flight.
- Sits between the next-PC logic, instruction memory and the decode/control stage of the single-cycle CPU.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0100, redirect target for misaligned fetch (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- npc_i  in  32  next PC from next-PC logic; sampled only on advance.
- stall_i  in  1  consumer not ready; holds the current instruction.
- redirect_i  in  1  flush current fetch and restart at redirect_pc_i.
- redirect_pc_i  in  32  redirect target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; equals pc_o.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  read data.
- inst_valid_o  out  1  inst_o/pc_o valid for decode.
- inst_o  out  32  fetched instruction.
- pc_o  out  32  PC of inst_o, which is also the current fetch PC.
- misalign_o  out  1  one-cycle pulse on misaligned target (optional feature only, otherwise tied 0).

Behaviour:
- Reset (rstn low, async):
  - pc=RESET_PC, state=IDLE, kill=0, inst_o=0.
  - imem_req_o, inst_valid_o and misalign_o all 0.
  - Reset asserted mid-fetch abandons the fetch. Any rvalid arriving after reset deasserts while in IDLE or REQ is ignored.
- States:
  - IDLE: one cycle after reset release, then -> REQ.
  - REQ: imem_req_o=1, imem_addr_o=pc. On gnt -> WAIT.
  - WAIT: on rvalid, if kill=0 capture inst_o=imem_rdata_i and go -> VALID. If kill=1, drop the data, clear kill and go -> REQ.
  - VALID: inst_valid_o=1.
    - stall_i=1: hold pc and inst_o; no request.
    - stall_i=0: pc<=npc_i and go -> REQ next cycle.
- Latency:
  - Advance to next request: 1 cycle.
  - With zero-wait memory (gnt same cycle as req, rvalid next cycle), throughput is one instruction per 3 cycles (REQ, WAIT, VALID).
- imem_req_o stays high in REQ until gnt; imem_addr_o is stable while req is high unless redirect_i is asserted.
- Only one outstanding request at a time; never a req while in WAIT.
- Redirect (redirect_i=1) has priority over everything except reset:
  - IDLE/REQ without gnt: pc<=redirect_pc_i, state -> REQ. The address change while req is high is permitted only here.
  - REQ with gnt the same cycle: pc<=redirect_pc_i, kill<=1, state -> WAIT.
  - WAIT without rvalid: pc<=redirect_pc_i, kill<=1, stay in WAIT.
  - WAIT with rvalid the same cycle: drop the data, pc<=redirect_pc_i, -> REQ.
  - VALID: inst_valid_o drops next cycle, pc<=redirect_pc_i, -> REQ. stall_i is ignored.
  - Back-to-back redirects: the last one wins; kill remains a single bit.
- PC arithmetic is 32-bit unsigned wrap: 32'hFFFF_FFFC followed by npc_i=0 is legal.
- inst_o holds its last value outside VALID; it is valid only when inst_valid_o=1.

Optional Feature:
- Macro: PC_FETCH_ALIGN_CHK_EN.
- Defined: before loading npc_i or redirect_pc_i, check bits [1:0]. If nonzero, load TRAP_PC instead and pulse misalign_o for 1 cycle, in the cycle the load happens.
- Not defined: targets are loaded unmodified, misalign_o is constant 0, and imem handles alignment.

Decomposition:
- Shared package ctrl_encode_def: fetch FSM state encodings (FS_IDLE, FS_REQ, FS_WAIT, FS_VALID, 2-bit), and RESET_PC/TRAP_PC default constants alongside the existing NPC_* op codes.
- One natural sub-module: pc_target_sel. This is a combinational priority mux of redirect vs npc vs TRAP_PC that also produces the misalign flag. The FSM and registers stay in pc_fetch_ctrl.

Test Plan:
- Reset then zero-wait memory returning 32'h00000013 at addr 0 → first req at addr 0 two cycles after rstn rises; inst_valid_o=1 with inst_o=32'h00000013 and pc_o=0; with npc_i=4 the next req is at addr 4.
- stall_i held 5 cycles in VALID → inst_o/pc_o unchanged, imem_req_o=0 throughout; release → req at npc_i within 1 cycle.
- gnt delayed 3 cycles with redirect_i to 32'h40 on the 2nd → imem_addr_o switches to 32'h40; the granted fetch is at 32'h40.
- Redirect to 32'h80 while in WAIT, stale rvalid returns 32'hDEADBEEF → data dropped, inst_valid_o stays 0, new req at 32'h80, then the correct instruction is presented.
- rstn pulsed low mid-WAIT → all outputs 0 immediately; pc=RESET_PC; a late rvalid is not captured.
- With PC_FETCH_ALIGN_CHK_EN defined: npc_i=32'h0000_0006 on advance → misalign_o pulses once, next req at TRAP_PC=32'h100. Without the macro, the next req is at 32'h6.
